// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's producer handshakes, pending-read query and
// regFile write port.
interface wb_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          aluValid;
  logic          aluReady;
  logic [AW-1:0] aluRd;
  logic [DW-1:0] aluData;
  logic          lsuValid;
  logic          lsuReady;
  logic [AW-1:0] lsuRd;
  logic [DW-1:0] lsuData;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic          rs1Pend;
  logic          rs2Pend;
  logic          wrEn;
  logic [AW-1:0] rd;
  logic [DW-1:0] dIn;
  logic          idle;

  modport master (
    output aluValid, aluRd, aluData, lsuValid, lsuRd, lsuData, rs1, rs2,
    input  aluReady, lsuReady, rs1Pend, rs2Pend, wrEn, rd, dIn, idle
  );

  modport slave (
    input  aluValid, aluRd, aluData, lsuValid, lsuRd, lsuData, rs1, rs2,
    output aluReady, lsuReady, rs1Pend, rs2Pend, wrEn, rd, dIn, idle
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: two per-source FIFOs (ALU, LSU) drained round-robin into a
// registered regFile write port, with pending-write lookup for rs1/rs2.
module wb_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [AW+DW-1:0] din,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             ready,
  output logic             ne,
  output logic [AW+DW-1:0] head,
  output logic             hit1,
  output logic             hit2
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][AW+DW-1:0] mem;
  logic [PW-1:0]               wptr, rptr;
  logic [CW-1:0]               cnt;
  logic [DEPTH-1:0]            ent_vld;

  // Ready comes from the current count only: a full FIFO stays not-ready even
  // in a cycle where it is being popped.
  assign ready = rst & (cnt < CW'(DEPTH));
  assign ne    = (cnt != '0);
  assign head  = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // A slot is live if its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] off;
    ent_vld = '0;
    hit1    = 1'b0;
    hit2    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off        = PW'(i) - rptr;
      ent_vld[i] = ({1'b0, off} < cnt);
      if (ent_vld[i] && (mem[i][AW+DW-1:DW] == rs1)) hit1 = 1'b1;
      if (ent_vld[i] && (mem[i][AW+DW-1:DW] == rs2)) hit2 = 1'b1;
    end
  end
endmodule

module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int NSRC = 2;  // 0 = ALU, 1 = LSU

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic { RR_ALU = 1'b0, RR_LSU = 1'b1 } rr_e;

  wb_req_t [NSRC-1:0] src_req, src_head;
  logic    [NSRC-1:0] src_vld, src_rdy, src_push, src_pop, src_ne, hit1, hit2;

  rr_e           rr_q, rr_d;
  logic          gnt_vld;
  logic          gnt_sel;
  logic          wr_en_q;
  logic [AW-1:0] rd_q;
  logic [DW-1:0] din_q;

  assign src_vld    = {bus.lsuValid, bus.aluValid};
  assign src_req[0] = {bus.aluRd, bus.aluData};
  assign src_req[1] = {bus.lsuRd, bus.lsuData};

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      // Writes to x0 complete the handshake but never occupy a slot.
      assign src_push[g] = src_vld[g] & src_rdy[g] & (src_req[g].rd != '0);

      wb_arb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (src_push[g]),
        .pop   (src_pop[g]),
        .din   (src_req[g]),
        .rs1   (bus.rs1),
        .rs2   (bus.rs2),
        .ready (src_rdy[g]),
        .ne    (src_ne[g]),
        .head  (src_head[g]),
        .hit1  (hit1[g]),
        .hit2  (hit2[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_q <= RR_ALU;
    else      rr_q <= rr_d;
  end

  // Grant the pointer's source on contention, else whichever is non-empty;
  // after any grant the pointer moves to the source not granted.
  always_comb begin
    rr_d    = rr_q;
    gnt_vld = |src_ne;
    gnt_sel = 1'b0;
    src_pop = '0;
    case (src_ne)
      2'b11:   gnt_sel = (rr_q == RR_LSU);
      2'b10:   gnt_sel = 1'b1;
      default: gnt_sel = 1'b0;
    endcase
    if (gnt_vld) begin
      src_pop[gnt_sel] = 1'b1;
      rr_d             = gnt_sel ? RR_ALU : RR_LSU;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q <= 1'b0;
      rd_q    <= '0;
      din_q   <= '0;
    end else if (gnt_vld) begin
      wr_en_q <= 1'b1;
      rd_q    <= src_head[gnt_sel].rd;
      din_q   <= src_head[gnt_sel].data;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign bus.aluReady = src_rdy[0];
  assign bus.lsuReady = src_rdy[1];
  assign bus.wrEn     = wr_en_q;
  assign bus.rd       = rd_q;
  assign bus.dIn      = din_q;
  assign bus.idle     = ~(|src_ne) & ~wr_en_q;
  assign bus.rs1Pend  = (bus.rs1 != '0) & ((|hit1) | (wr_en_q & (rd_q == bus.rs1)));
  assign bus.rs2Pend  = (bus.rs2 != '0) & ((|hit2) | (wr_en_q & (rd_q == bus.rs2)));
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter that shares the single regFile write port (wrEn/rd/dIn) between two producers: the ALU and the load/store unit (LSU).
- Each producer has a small per-source FIFO with a valid/ready handshake. The block drains the FIFOs round-robin and discards writes to x0.
- It also flags reads of registers that still have a write in flight, for the issue stage's stall logic.

Parameters:
- DEPTH, 2, entries per source FIFO (power of two, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- aluValid  in  1  ALU write request
- aluReady  out  1  ALU FIFO can accept
- aluRd  in  AW  ALU destination register
- aluData  in  DW  ALU write data
- lsuValid  in  1  LSU write request
- lsuReady  out  1  LSU FIFO can accept
- lsuRd  in  AW  LSU destination register
- lsuData  in  DW  LSU write data
- rs1  in  AW  read address 1 to check for pending writes
- rs2  in  AW  read address 2 to check for pending writes
- rs1Pend  out  1  write to rs1 in flight
- rs2Pend  out  1  write to rs2 in flight
- wrEn  out  1  regFile write enable (registered)
- rd  out  AW  regFile write address (registered)
- dIn  out  DW  regFile write data (registered)
- idle  out  1  both FIFOs empty and wrEn low

Behaviour:
- Reset (rst low, async):
  - FIFOs emptied; wrEn=0, rd=0, dIn=0.
  - Round-robin pointer set to ALU; aluReady=lsuReady=0; rs1Pend=rs2Pend=0.
  - Mid-operation reset discards all queued and in-output writes.
- Ready:
  - xReady = rst & (countX < DEPTH), from the current count.
  - No pass-through when full: a full FIFO holds ready low even in a cycle where it dequeues.
- Accept:
  - valid & ready at a rising edge accepts the request.
  - Nonzero rd: the entry is enqueued.
  - rd==0: the handshake completes but nothing is enqueued and no write is generated.
  - valid with ready low: the request is not accepted; the producer holds rd/data stable until accepted.
- Arbitration, once per cycle, on FIFO heads:
  - Both FIFOs non-empty: grant the pointer's source, then move the pointer to the other source.
  - One FIFO non-empty: grant it; the pointer then points to the other source.
  - Neither non-empty: no grant; pointer unchanged.
- Output stage:
  - The granted head is popped and registered into wrEn=1/rd/dIn at the same edge.
  - wrEn is high for exactly one cycle per entry.
  - With no grant: wrEn=0; rd and dIn hold their last values.
- Latency:
  - Request accepted at edge N → wrEn high in the cycle after edge N+1 → regFile writes at edge N+2.
  - Throughput is one write per cycle total.
- Ordering:
  - FIFO order is preserved within a source.
  - Across sources, writes occur in grant order. Upstream must not issue two in-flight writes to the same rd from different sources.
- Simultaneous events:
  - Enqueue and dequeue on the same FIFO in one edge: count unchanged, data correct.
  - Both sources accepted in one edge: both enqueue.
- Pending flags (combinational on rs1/rs2):
  - rsXPend=1 iff rsX≠0 and rsX matches a valid FIFO entry of either source, or rsX matches rd while wrEn=1.
  - rsX=0 always gives 0.
- Wrap-around: FIFO read/write pointers wrap modulo DEPTH. The count distinguishes full from empty.

Test Plan:
- Reset: drive rst=0 mid-stream with 2 ALU + 1 LSU entries queued → all outputs at reset values immediately. After rst=1: idle=1, aluReady=lsuReady=1, no wrEn pulse.
- Single write: ALU rd=5, data=32'hFAFAFA05 accepted at edge N → wrEn=1, rd=5, dIn=32'hFAFAFA05 in the cycle after edge N+1. rs1=5 gives rs1Pend=1 from after edge N through that wrEn cycle, 0 afterwards.
- Round-robin: ALU writes rd=1,2 and LSU writes rd=3,4 all queued → grant order rd=1,3,2,4 on consecutive cycles, wrEn high 4 cycles.
- Back-pressure: ALU sends 3 back-to-back with LSU busy, DEPTH=2 → aluReady=0 after 2 accepts; third accepted after first drains; order 1,2,3 preserved.
- x0 filter: LSU rd=0, data=32'hDEADBEEF accepted → no wrEn pulse; rs1=0 gives rs1Pend=0; idle stays 1.
- Same-edge enqueue/dequeue: ALU FIFO holding 1 entry, new ALU request → count stays 1, both writes emerge in order. Full FIFO dequeuing still shows aluReady=0 that cycle.
